prefix_adder_pipe: RTL and testbench
====================================

# prefix_adder_pipe

Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor with a valid/ready handshake and status flags. It succeeds the fixed 32-bit combinational prefix adder: width and pipeline depth are configurable, and it adds subtract mode, signed overflow, zero detect and output backpressure. It sits between operand-producing logic and any consumer, such as a counter-driven self-test harness or a datapath ALU stage.

## Interface
- WIDTH, 32, operand width; power of two, 4..64; LEVELS = log2(WIDTH) prefix levels.
- REG_EVERY, 2, pipeline register after every REG_EVERY prefix levels; 1..LEVELS.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: y = a + b + cin; 1: y = a − b (a + ~b + 1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH−1; in subtract mode 1 means no borrow (a ≥ b unsigned).
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  y == 0.

## Operation
- Stage 0 (input register) captures a, b_eff = sub ? ~b : b, c0 = sub ? 1 : cin, and valid. It computes bitwise generate g = a&b_eff, propagate p = a^b_eff.
- Prefix network: LEVELS Kogge-Stone levels; level k combines (G,P) with the pair at distance 2^k. c0 is folded in as generate at position −1, so carry[i] = G[i−1:−1].
- Internal registers: ceil(LEVELS/REG_EVERY) − 1 register ranks, one after each full group of REG_EVERY levels. Each rank carries the (G,P) vectors, the original p vector, c0 and valid.
- Output register: y = p ^ {carry[WIDTH−1:1], c0}; cout = carry[WIDTH]; ovf = carry[WIDTH] ^ carry[WIDTH−1]; zero = ~|y.
- Flow control is a global stall. stall = out_valid & ~out_ready. When stall=1, every pipeline register, including valid bits, holds its value. in_ready = ~stall.
- A beat transfers in when in_valid & in_ready, and out when out_valid & out_ready.
- Bubbles (valid=0 ranks) advance normally and are not collapsed. Data registers of invalid ranks may toggle, but out_valid=0 masks them.
- Results emerge in input order. No beat is dropped or duplicated.

## Timing
- LATENCY = 2 + ceil(LEVELS/REG_EVERY) − 1 cycles from the accepting edge to out_valid, absent stalls. Defaults (WIDTH=32, REG_EVERY=2): LATENCY = 4. With REG_EVERY=LEVELS: LATENCY = 2.
- Throughput: one beat per cycle while out_ready=1.
- Reset (async assert, sync release): all valid bits = 0, out_valid=0, y=0, cout=0, ovf=0, zero=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded immediately. No output follows until new input arrives.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid, a or b to any output.
- Held outputs: y, cout, ovf and zero stay stable while out_valid=1 and out_ready=0.
- Simultaneous stall release and new input: if out_ready rises in the same cycle as in_valid, the beat is accepted and the pipeline advances that edge.
- Wrap-around: 0xFFFFFFFF + 1 (cin=0) gives y=0, cout=1, zero=1, ovf=0.

## Test plan
- Add, default params: a=0x0000_0005, b=0x0000_0003, cin=1, sub=0 → 4 cycles later y=0x0000_0009, cout=0, ovf=0, zero=0.
- Boundary: a=0xFFFF_FFFF, b=0x0000_0001, sub=0 → y=0, cout=1, zero=1, ovf=0. Then a=0x7FFF_FFFF, b=1 → y=0x8000_0000, ovf=1, cout=0.
- Subtract: a=3, b=5, sub=1, cin=1 (ignored) → y=0xFFFF_FFFE, cout=0 (borrow). Then a=5, b=5 → y=0, zero=1, cout=1.
- Streaming with backpressure: drive a=i, b=2i for i=0..63 back-to-back, with out_ready toggling pseudo-randomly. Outputs y=3i must appear in order with none lost, and y must stay stable during stalls.
- Reset mid-flight: accept 3 beats, assert rst on cycle 2 → out_valid=0 and all outputs 0 immediately. After release, no stale result appears.
- Parameter sweep: WIDTH ∈ {4,8,16,64} × REG_EVERY ∈ {1,LEVELS}, 1000 random beats each, compared against a behavioural a+b+cin / a−b model. Measured latency must equal 2 + ceil(LEVELS/REG_EVERY) − 1.

Source files
------------

// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Kogge-Stone adder/subtractor with valid/ready flow control and status flags
module prefix_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int T = LEVELS - 1;
  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH:0]   g0, p0;
  logic [WIDTH-1:0] pr0;
  logic             v0;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;
  // input rank: bitwise generate/propagate, carry-in sits at index 0 as a pure generate
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v0  <= 1'b0;
      g0  <= '0;
      p0  <= '0;
      pr0 <= '0;
    end else if (!stall) begin
      v0  <= in_valid;
      g0  <= {a & b_eff, c0};
      p0  <= {a ^ b_eff, 1'b0};
      pr0 <= a ^ b_eff;
    end
  for (genvar k = 0; k < LEVELS; k++) begin : lvl
    logic [WIDTH:0]   gi, pi, go, po;
    logic [WIDTH-1:0] pr;
    logic             v;
    if (k == 0) begin : s
      assign gi = g0;
      assign pi = p0;
      assign pr = pr0;
      assign v  = v0;
    end else if (k % REG_EVERY == 0) begin : s
      // pipeline rank between level groups
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          v  <= 1'b0;
          gi <= '0;
          pi <= '0;
          pr <= '0;
        end else if (!stall) begin
          v  <= lvl[k-1].v;
          gi <= lvl[k-1].go;
          pi <= lvl[k-1].po;
          pr <= lvl[k-1].pr;
        end
    end else begin : s
      assign gi = lvl[k-1].go;
      assign pi = lvl[k-1].po;
      assign pr = lvl[k-1].pr;
      assign v  = lvl[k-1].v;
    end
    assign go = gi | (pi & (gi << (1 << k)));
    assign po = pi & ~(~pi << (1 << k));
  end
  // the top group spans WIDTH positions and stops one short of the carry-in, so fold it in here
  assign carry = lvl[T].go | (lvl[T].po & {lvl[T].go[0], {WIDTH{1'b0}}});
  assign sum   = lvl[T].pr ^ carry[WIDTH-1:0];
  // output rank: sum and status flags, held while the consumer stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (!stall) begin
      out_valid <= lvl[T].v;
      y         <= sum;
      cout      <= carry[WIDTH];
      ovf       <= carry[WIDTH] ^ carry[WIDTH-1];
      zero      <= ~|sum;
    end
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// tb_prefix_adder_pipe: directed and random checks of several adder configurations against an arithmetic model
module tb_prefix_adder_pipe;
  localparam int N = 9;
  typedef struct packed {
    logic [63:0] y;
    logic        c, o, z;
    int          acc;
  } exp_t;

  function automatic int wof(int g);
    case (g)
      0: return 32;
      1, 2: return 4;
      3, 4: return 8;
      5, 6: return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int rof(int g);
    if (g == 0) return 2;
    return (g % 2 == 1) ? 1 : $clog2(wof(g));
  endfunction

  function automatic int lat_of(int g);
    return ($clog2(wof(g)) + rof(g) - 1) / rof(g) + 1;
  endfunction

  function automatic exp_t model(int w, logic [63:0] xa, logic [63:0] xb, logic xc, logic xs);
    logic [63:0] m, be;
    logic [64:0] f;
    exp_t e;
    m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    be = (xs ? ~xb : xb) & m;
    f = {1'b0, xa & m} + {1'b0, be} + 65'(xs | xc);
    e.y = f[63:0] & m;
    e.c = f[w];
    e.o = (xa[w-1] == be[w-1]) && (e.y[w-1] != xa[w-1]);
    e.z = (e.y == 64'd0);
    e.acc = 0;
    return e;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] a, b;
  logic cin, sub;
  logic iv[N], ordy[N], ir[N], ov[N], co[N], of[N], zr[N];
  logic [63:0] yv[N];
  exp_t q[N][$];
  int errs = 0, checks = 0, cyc = 0;
  bit bp = 0, acc0 = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : cfg
    localparam int W = wof(g);
    localparam int R = rof(g);
    logic [W-1:0] yy;
    prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(R)) dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]),
      .a(a[W-1:0]), .b(b[W-1:0]), .cin(cin), .sub(sub),
      .out_valid(ov[g]), .out_ready(ordy[g]), .y(yy),
      .cout(co[g]), .ovf(of[g]), .zero(zr[g])
    );
    assign yv[g] = 64'(yy);
  end

  task automatic chk(string tag, logic [127:0] o, logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int g = 0; g < N; g++) s += q[g].size();
    return s;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc0 = 0;
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        q[g].delete();
        continue;
      end
      if (ov[g]) begin
        if (q[g].size() == 0) chk($sformatf("spurious_out%0d", g), 128'(ov[g]), 128'(0));
        else begin
          chk($sformatf("out%0d", g), 128'({yv[g], co[g], of[g], zr[g]}),
              128'({q[g][0].y, q[g][0].c, q[g][0].o, q[g][0].z}));
          if (!bp || g > 0) chk($sformatf("lat%0d", g), 128'(cyc - q[g][0].acc + 1), 128'(lat_of(g)));
          if (ordy[g]) void'(q[g].pop_front());
        end
      end
      if (iv[g] && ir[g]) begin
        e = model(wof(g), a, b, cin, sub);
        e.acc = cyc + 1;
        q[g].push_back(e);
        if (g == 0) acc0 = 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (pending() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", 128'(pending()), 128'(0));
  endtask

  task automatic run1(string tag, logic [31:0] xa, logic [31:0] xb, logic xc, logic xs,
                      logic [31:0] ey, logic ec, logic eo, logic ez);
    int n;
    a = {32'd0, xa};
    b = {32'd0, xb};
    cin = xc;
    sub = xs;
    iv[0] = 1;
    tick();
    iv[0] = 0;
    n = 1;
    while (!ov[0] && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(4));
    chk(tag, 128'({yv[0][31:0], co[0], of[0], zr[0]}), 128'({ey, ec, eo, ez}));
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    bit v;
    a = '0; b = '0; cin = 0; sub = 0;
    for (int g = 0; g < N; g++) begin
      iv[g] = 0;
      ordy[g] = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 128'({ov[0], yv[0], co[0], of[0], zr[0]}), 128'(0));
    rst = 0;
    tick();
    chk("in_ready_after_reset", 128'(ir[0]), 128'(1));
    run1("add5_3", 32'h5, 32'h3, 1, 0, 32'h9, 0, 0, 0);
    run1("wrap", 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0, 1);
    run1("ovf_pos", 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1, 0);
    run1("sub_borrow", 32'h3, 32'h5, 1, 1, 32'hFFFF_FFFE, 0, 0, 0);
    run1("sub_equal", 32'h5, 32'h5, 0, 1, 32'h0, 1, 0, 1);
    run1("sub_ovf", 32'h8000_0000, 32'h1, 0, 1, 32'h7FFF_FFFF, 1, 1, 0);
    // streaming a=i, b=2i under random backpressure
    bp = 1;
    cin = 0;
    sub = 0;
    for (int i = 0; i < 64; i++) begin
      a = 64'(i);
      b = 64'(2 * i);
      iv[0] = 1;
      n = 0;
      do begin
        ordy[0] = 1'($urandom);
        tick();
        n++;
      end while (!acc0 && n < 100);
      chk("stream_accept", 128'(acc0), 128'(1));
    end
    iv[0] = 0;
    ordy[0] = 1;
    drain();
    bp = 0;
    // reset while beats are in flight
    a = 64'h11; b = 64'h22;
    iv[0] = 1;
    tick();
    tick();
    rst = 1;
    #1;
    chk("midrst_out", 128'({ov[0], yv[0], co[0], of[0], zr[0]}), 128'(0));
    iv[0] = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_stale", 128'(ov[0]), 128'(0));
    end
    // random sweep across widths and register spacings
    cnt = 0;
    n = 0;
    while (cnt < 1000 && n < 3000) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'($urandom);
      sub = 1'($urandom);
      v = ($urandom % 8) != 0;
      for (int g = 1; g < N; g++) iv[g] = v;
      tick();
      if (v) cnt++;
      n++;
    end
    chk("sweep_beats", 128'(cnt), 128'(1000));
    for (int g = 1; g < N; g++) iv[g] = 0;
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
